vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Shares one asynchronous video SRAM between two requesters: the display scanline fetcher (pixel reads) and the CPU bus port (read/write).
- Owns all SRAM strobes, the SRAM address mux and the data-bus output enable.
- Sits between the CPU bus/external-memory interface and the VGA timing generator.
- Display reads have priority. CPU accesses fill the gaps between display reads, and CPU accesses outside [MEM_BEGIN, MEM_END] are ignored.

Parameters:
- ADDR_W, 20, SRAM/CPU address width.
- DATA_W, 32, data width.
- MEM_BEGIN, 1, first CPU address decoded by this block (inclusive).
- MEM_END, 2, last CPU address decoded (inclusive); the SRAM address is addr_in - MEM_BEGIN.
- ACC_CYC, 2, strobe-low cycles per SRAM access (legal range 1..15).
- STARVE_MAX, 4, consecutive display grants allowed while the CPU waits (only used with the optional feature).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- disp_req  in  1  display read request (level); held until disp_ack.
- disp_addr  in  ADDR_W  display read address; stable while disp_req is high.
- disp_ack  out  1  one-cycle pulse; disp_data is valid in the same cycle.
- disp_data  out  DATA_W  captured display read data.
- addr_in  in  ADDR_W  CPU address.
- data_in  in  DATA_W  CPU write data.
- read_q  in  1  CPU read request (level, held until read_dn).
- write_q  in  1  CPU write request (level, held until write_dn).
- rw_halt  in  1  high means no new CPU grant; a CPU access already in progress completes.
- data_out  out  DATA_W  CPU read data; valid while read_dn is high, 0 otherwise.
- read_dn  out  1  one-cycle CPU read-done pulse.
- write_dn  out  1  one-cycle CPU write-done pulse.
- sram_addr  out  ADDR_W  SRAM address.
- sram_dout  out  DATA_W  SRAM write data.
- sram_din  in  DATA_W  SRAM read data.
- sram_doe  out  1  data-bus output enable (drive sram_dout).
- sram_ce_  out  1  chip enable, active-low.
- sram_oe_  out  1  output enable, active-low.
- sram_we_  out  1  write enable, active-low.

Behaviour:
- Reset (rst=0, asynchronous) forces the following, and any access in progress is abandoned with no done pulse:
  - state=IDLE;
  - sram_ce_/oe_/we_=1, sram_doe=0;
  - sram_addr=0, sram_dout=0;
  - disp_ack=0, disp_data=0;
  - read_dn=0, write_dn=0, data_out=0;
  - cycle counter=0, starve counter=0.
- CPU request valid (cpu_v) = (read_q|write_q) & MEM_BEGIN<=addr_in<=MEM_END & ~rw_halt. If read_q and write_q are both high, the write is taken.
- States: IDLE, DRD (display read), CRD (CPU read), CWR (CPU write), TURN.
- IDLE transitions:
  - disp_req -> DRD;
  - else cpu_v & write_q -> CWR;
  - else cpu_v -> CRD.
  - Address and write data are registered on entry.
- DRD / CRD:
  - ce_=0, oe_=0 for ACC_CYC cycles.
  - sram_din is sampled on the clock edge ending the last cycle.
  - Next cycle: disp_ack (DRD) or read_dn+data_out (CRD) pulse.
  - FSM goes back to IDLE in that same done cycle, so a new grant can start the following cycle.
- CWR:
  - ce_=0, we_=0, doe=1 for ACC_CYC cycles; sram_dout is held.
  - we_ rises one cycle before doe falls (data hold). That hold cycle is the TURN state: ce_=1, we_=1, doe=1, and write_dn pulses in it.
  - TURN -> IDLE.
- Latency from IDLE with no contention:
  - read: request to done = ACC_CYC+1 cycles;
  - write: request to done = ACC_CYC+1 cycles, with the bus busy for ACC_CYC+1.
- Requester rules:
  - A requester must drop its request in the cycle after its done pulse, or it is re-served (not an error).
  - Display and CPU raised in the same IDLE cycle: display wins; the CPU waits.
- Out-of-window CPU requests: never granted, no done pulse (the window owner elsewhere answers). rw_halt going high during CRD/CWR does not abort the access.
- Address width: the subtraction addr_in-MEM_BEGIN is truncated to ADDR_W.
- Strobes are registered outputs, so no glitches.

Optional Feature:
- Macro: VRAM_STARVE_GUARD_EN.
- With the macro:
  - an up-counter counts display grants taken while cpu_v was high;
  - when it reaches STARVE_MAX and cpu_v is high in IDLE, the CPU is granted even if disp_req is high;
  - the counter clears on any CPU grant or when cpu_v is low.
- Without the macro: strict display priority and no counter. A CPU request may wait indefinitely under continuous disp_req.

Test Plan:
- Reset mid-CWR (rst low in the 2nd strobe cycle): next edge shows ce_/we_=1, doe=0, no write_dn; after release, state IDLE and all outputs 0/1 as specified.
- CPU read with ACC_CYC=2, addr_in=2, MEM_BEGIN=1, sram_din=0xDEADBEEF: sram_addr=1, oe_ low for 2 cycles, read_dn + data_out=0xDEADBEEF 3 cycles after read_q.
- CPU write addr_in=1, data_in=0x12345678: we_ low 2 cycles with doe=1 and sram_dout=0x12345678; TURN cycle has we_=1, doe=1, write_dn=1; next cycle doe=0.
- Display and CPU read raised in the same cycle: disp_ack with disp_data first (cycle 3); CPU read_dn at cycle 6.
- Out-of-window addr_in=5 with read_q held 20 cycles: no strobes, no read_dn. rw_halt=1 with an in-window request: no grant until rw_halt=0.
- VRAM_STARVE_GUARD_EN, STARVE_MAX=4, disp_req held high with CPU write pending: exactly 4 disp_ack, then write_dn, then display resumes. Without the macro: no write_dn within 100 cycles.

Source files
------------

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - display-priority arbiter sharing one async video SRAM with the CPU port
// Optional macro VRAM_STARVE_GUARD_EN: bounds consecutive display grants while a CPU access waits.
module vram_arbiter #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 32,
  parameter int MEM_BEGIN  = 1,
  parameter int MEM_END    = 2,
  parameter int ACC_CYC    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_ack,
  output logic [DATA_W-1:0] disp_data,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read_q,
  input  logic              write_q,
  input  logic              rw_halt,
  output logic [DATA_W-1:0] data_out,
  output logic              read_dn,
  output logic              write_dn,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dout,
  input  logic [DATA_W-1:0] sram_din,
  output logic              sram_doe,
  output logic              sram_ce_,
  output logic              sram_oe_,
  output logic              sram_we_
);

  if (ACC_CYC < 1 || ACC_CYC > 15 || STARVE_MAX < 1) begin : g_param_check
    $error("vram_arbiter: ACC_CYC must be 1..15 and STARVE_MAX at least 1");
  end

  typedef enum logic [2:0] {IDLE, DRD, CRD, CWR, TURN} state_e;

  state_e            state_q;
  logic [3:0]        cyc_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] dout_q, disp_data_q, data_out_q;
  logic              ce_q, oe_q, we_q, doe_q;
  logic              disp_ack_q, read_dn_q, write_dn_q;

  logic              in_win, cpu_v, cpu_first;
  logic [ADDR_W-1:0] cpu_addr_d;

  assign in_win     = (addr_in >= ADDR_W'(MEM_BEGIN)) && (addr_in <= ADDR_W'(MEM_END));
  assign cpu_v      = (read_q | write_q) & in_win & ~rw_halt;
  assign cpu_addr_d = addr_in - ADDR_W'(MEM_BEGIN);

`ifdef VRAM_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_q;

  assign cpu_first = cpu_v && (starve_q >= SW'(STARVE_MAX));

  // Counts display grants taken over a waiting CPU; any CPU grant or idle CPU clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
    end else if (!cpu_v) begin
      starve_q <= '0;
    end else if (state_q == IDLE) begin
      if (cpu_first || !disp_req) starve_q <= '0;
      else                        starve_q <= starve_q + SW'(1);
    end
  end
`else
  assign cpu_first = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cyc_q       <= '0;
      addr_q      <= '0;
      dout_q      <= '0;
      disp_data_q <= '0;
      data_out_q  <= '0;
      ce_q        <= 1'b1;
      oe_q        <= 1'b1;
      we_q        <= 1'b1;
      doe_q       <= 1'b0;
      disp_ack_q  <= 1'b0;
      read_dn_q   <= 1'b0;
      write_dn_q  <= 1'b0;
    end else begin
      disp_ack_q <= 1'b0;
      read_dn_q  <= 1'b0;
      write_dn_q <= 1'b0;
      data_out_q <= '0;
      case (state_q)
        IDLE: begin
          cyc_q <= '0;
          if (disp_req && !cpu_first) begin
            state_q <= DRD;
            addr_q  <= disp_addr;
            ce_q    <= 1'b0;
            oe_q    <= 1'b0;
          end else if (cpu_v) begin
            addr_q <= cpu_addr_d;
            dout_q <= data_in;
            ce_q   <= 1'b0;
            if (write_q) begin
              state_q <= CWR;
              we_q    <= 1'b0;
              doe_q   <= 1'b1;
            end else begin
              state_q <= CRD;
              oe_q    <= 1'b0;
            end
          end
        end
        DRD, CRD: begin
          if (cyc_q == 4'(ACC_CYC - 1)) begin
            ce_q    <= 1'b1;
            oe_q    <= 1'b1;
            state_q <= IDLE;
            if (state_q == DRD) begin
              disp_ack_q  <= 1'b1;
              disp_data_q <= sram_din;
            end else begin
              read_dn_q  <= 1'b1;
              data_out_q <= sram_din;
            end
          end else begin
            cyc_q <= cyc_q + 4'd1;
          end
        end
        CWR: begin
          // Strobes release first; the bus stays driven through TURN for data hold.
          if (cyc_q == 4'(ACC_CYC - 1)) begin
            ce_q       <= 1'b1;
            we_q       <= 1'b1;
            write_dn_q <= 1'b1;
            state_q    <= TURN;
          end else begin
            cyc_q <= cyc_q + 4'd1;
          end
        end
        TURN: begin
          doe_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign disp_ack  = disp_ack_q;
  assign disp_data = disp_data_q;
  assign data_out  = data_out_q;
  assign read_dn   = read_dn_q;
  assign write_dn  = write_dn_q;
  assign sram_addr = addr_q;
  assign sram_dout = dout_q;
  assign sram_doe  = doe_q;
  assign sram_ce_  = ce_q;
  assign sram_oe_  = oe_q;
  assign sram_we_  = we_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - randomized and directed bench for vram_arbiter against a timestamp model
module tb_vram_arbiter;
  localparam int ADDR_W = 20, DATA_W = 32, MEM_BEGIN = 1, MEM_END = 2, ACC = 2, STARVE_MAX = 4;
`ifdef VRAM_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b0;
  logic disp_req = 1'b0, read_q = 1'b0, write_q = 1'b0, rw_halt = 1'b0;
  logic [ADDR_W-1:0] disp_addr = '0, addr_in = '0;
  logic [DATA_W-1:0] data_in = '0;
  logic disp_ack, read_dn, write_dn, sram_doe, sram_ce_, sram_oe_, sram_we_;
  logic [DATA_W-1:0] disp_data, data_out, sram_dout, sram_din;
  logic [ADDR_W-1:0] sram_addr;

  vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_BEGIN(MEM_BEGIN), .MEM_END(MEM_END),
                 .ACC_CYC(ACC), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst), .disp_req(disp_req), .disp_addr(disp_addr), .disp_ack(disp_ack),
    .disp_data(disp_data), .addr_in(addr_in), .data_in(data_in), .read_q(read_q),
    .write_q(write_q), .rw_halt(rw_halt), .data_out(data_out), .read_dn(read_dn),
    .write_dn(write_dn), .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_din(sram_din),
    .sram_doe(sram_doe), .sram_ce_(sram_ce_), .sram_oe_(sram_oe_), .sram_we_(sram_we_));

  always #5 clk = ~clk;

  function automatic logic [31:0] hash(logic [19:0] a);
    return (32'(a) * 32'h9E3779B1) ^ 32'hA5A50F0F;
  endfunction
  assign sram_din = hash(sram_addr);

  int checks = 0, errors = 0, cyc = 0;
  // Model: at most one access in flight, described by grant cycle, kind and operands.
  int free_cyc = 0, act_g = 0, act_k = 0, starve = 0;
  bit act_v = 1'b0, hold_disp = 1'b0;
  logic [19:0] act_addr = '0;
  logic [31:0] act_wd = '0, act_rd = '0, exp_disp_data = '0;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    act_v = 1'b0; starve = 0; free_cyc = 0; exp_disp_data = '0;
  endtask

  task automatic model_decide();
    bit cv, force_cpu, gd, gc;
    if (!rst) begin model_reset(); return; end
    cv = (read_q | write_q) && addr_in >= 20'(MEM_BEGIN) && addr_in <= 20'(MEM_END) && !rw_halt;
    gd = 1'b0; gc = 1'b0;
    if (cyc >= free_cyc) begin
      force_cpu = GUARD && cv && starve >= STARVE_MAX;
      if (disp_req && !force_cpu) gd = 1'b1;
      else if (cv)                gc = 1'b1;
    end
    if (gd) begin
      act_v = 1'b1; act_g = cyc; act_k = 0; act_addr = disp_addr;
      act_rd = hash(disp_addr); free_cyc = cyc + ACC + 1;
    end
    if (gc) begin
      act_v = 1'b1; act_g = cyc; act_k = write_q ? 2 : 1;
      act_addr = 20'(addr_in - 20'(MEM_BEGIN)); act_wd = data_in; act_rd = hash(act_addr);
      free_cyc = cyc + ACC + 1 + ((act_k == 2) ? 1 : 0);
    end
    if (!cv || gc) starve = 0;
    else if (gd)   starve++;
  endtask

  task automatic check_outputs();
    int d;
    logic [6:0] es;
    logic [31:0] edo;
    es = 7'b1110000; edo = '0;
    d = cyc - act_g;
    if (act_v && d >= 1 && d <= ACC) begin
      check("sram_addr", 64'(sram_addr), 64'(act_addr));
      if (act_k == 2) begin
        es = 7'b0101000;
        check("sram_dout", 64'(sram_dout), 64'(act_wd));
      end else es = 7'b0010000;
    end else if (act_v && d == ACC + 1) begin
      case (act_k)
        0: begin es = 7'b1110100; exp_disp_data = act_rd; end
        1: begin es = 7'b1110010; edo = act_rd; end
        default: begin es = 7'b1111001; check("turn_dout", 64'(sram_dout), 64'(act_wd)); end
      endcase
    end
    check("strobes{ce,oe,we,doe,ack,rdn,wdn}",
          64'({sram_ce_, sram_oe_, sram_we_, sram_doe, disp_ack, read_dn, write_dn}), 64'(es));
    check("data_out", 64'(data_out), 64'(edo));
    check("disp_data", 64'(disp_data), 64'(exp_disp_data));
  endtask

  task automatic tick();
    model_decide();
    @(posedge clk); #1;
    cyc++;
    check_outputs();
    if (disp_ack && !hold_disp) disp_req = 1'b0;
    if (read_dn) read_q = 1'b0;
    if (write_dn) begin write_q = 1'b0; read_q = 1'b0; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int t0, n_ack, t_ack, t_rd, n_wr, oow_t;
    bit seen;
    // Reset state
    repeat (2) tick();
    check("rst_sram_addr", 64'(sram_addr), 64'd0);
    check("rst_sram_dout", 64'(sram_dout), 64'd0);
    rst = 1'b1;
    tick();

    // CPU read latency
    addr_in = 20'd2; read_q = 1'b1; t0 = cyc; seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin tick(); if (read_dn) seen = 1'b1; end
    check("rd_latency", 64'(cyc - t0), 64'(ACC + 1));
    tick();

    // CPU write latency
    addr_in = 20'd1; data_in = 32'h12345678; write_q = 1'b1; t0 = cyc; seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin tick(); if (write_dn) seen = 1'b1; end
    check("wr_latency", 64'(cyc - t0), 64'(ACC + 1));
    tick(); tick();

    // Display and CPU raised together: display first
    disp_req = 1'b1; disp_addr = 20'h0ABCD; addr_in = 20'd2; read_q = 1'b1;
    t0 = cyc; t_ack = -1; t_rd = -1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (disp_ack && t_ack < 0) t_ack = cyc - t0;
      if (read_dn && t_rd < 0) t_rd = cyc - t0;
    end
    check("same_cycle_ack", 64'(t_ack), 64'(3));
    check("same_cycle_rdn", 64'(t_rd), 64'(6));

    // Out-of-window request is ignored
    addr_in = 20'd5; read_q = 1'b1; seen = 1'b0;
    for (int i = 0; i < 20; i++) begin tick(); if (read_dn || !sram_ce_) seen = 1'b1; end
    check("oow_no_access", 64'(seen), 64'd0);
    read_q = 1'b0;

    // rw_halt blocks new grants until released
    addr_in = 20'd2; read_q = 1'b1; rw_halt = 1'b1; seen = 1'b0;
    for (int i = 0; i < 10; i++) begin tick(); if (read_dn || !sram_ce_) seen = 1'b1; end
    check("halt_no_grant", 64'(seen), 64'd0);
    rw_halt = 1'b0; seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin tick(); if (read_dn) seen = 1'b1; end
    check("halt_release_done", 64'(seen), 64'd1);
    tick();

    // Continuous display traffic with a pending CPU write
    hold_disp = 1'b1; disp_req = 1'b1; disp_addr = 20'h00777;
    addr_in = 20'd1; data_in = 32'hCAFEF00D; write_q = 1'b1;
    n_ack = 0; n_wr = 0;
    for (int i = 0; i < (GUARD ? 60 : 100) && n_wr == 0; i++) begin
      tick();
      if (disp_ack) n_ack++;
      if (write_dn) n_wr++;
    end
    if (GUARD) begin
      check("starve_acks_before_write", 64'(n_ack), 64'(STARVE_MAX));
      check("starve_write_done", 64'(n_wr), 64'd1);
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin tick(); if (disp_ack) seen = 1'b1; end
      check("display_resumes", 64'(seen), 64'd1);
    end else begin
      check("strict_priority_no_write", 64'(n_wr), 64'd0);
    end
    hold_disp = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !(write_q == 1'b0 && disp_req == 1'b0); i++) tick();
    check("drain_requests", 64'({write_q, disp_req}), 64'd0);
    tick(); tick();

    // Reset in the second strobe cycle of a write
    addr_in = 20'd1; data_in = 32'h55AA55AA; write_q = 1'b1;
    tick(); tick();
    rst = 1'b0; #1;
    model_reset(); write_q = 1'b0;
    check_outputs();
    check("midrst_sram_addr", 64'(sram_addr), 64'd0);
    check("midrst_sram_dout", 64'(sram_dout), 64'd0);
    tick(); tick();
    rst = 1'b1;
    tick(); tick();

    // Randomized traffic
    oow_t = 0;
    for (int i = 0; i < 1500; i++) begin
      if (!disp_req && $urandom_range(0, 3) == 0) begin
        disp_req = 1'b1; disp_addr = 20'($urandom);
      end
      if (!read_q && !write_q && $urandom_range(0, 2) == 0) begin
        int r;
        addr_in = 20'($urandom_range(0, 4)); data_in = $urandom;
        r = $urandom_range(0, 3);
        read_q = (r != 1); write_q = (r != 0); oow_t = 0;
      end
      if ((read_q || write_q) && (addr_in < 20'(MEM_BEGIN) || addr_in > 20'(MEM_END))) begin
        oow_t++;
        if (oow_t > 5) begin read_q = 1'b0; write_q = 1'b0; end
      end
      rw_halt = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
